// File: rtl/gpio_mux_ctrl.sv
// Purpose: registered GPIO pin mux; runtime select table, parked state, guard on ownership change.
// Latency: one cycle from io_oeb/io_out to pads; a new owner appears GUARD_CYCLES+1 edges after its write.
// Backpressure: none; cfg writes are always accepted, out-of-range pins flag cfg_err one cycle later.
module gpio_mux_ctrl #(
  parameter int NUM_PINS     = 38,
  parameter int NUM_PROJ     = 13,
  parameter int SEL_W        = 4,
  parameter int GUARD_CYCLES = 2
) (
  input  logic                         clk,
  input  logic                         nrst,
  input  logic [NUM_PROJ*NUM_PINS-1:0] io_oeb,
  input  logic [NUM_PROJ*NUM_PINS-1:0] io_out,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_PINS)-1:0]  cfg_pin,
  input  logic [SEL_W-1:0]             cfg_sel,
  input  logic                         park_all,
  output logic [NUM_PINS-1:0]          muxxed_io_oeb,
  output logic [NUM_PINS-1:0]          muxxed_io_out,
  output logic [NUM_PINS-1:0]          pin_busy,
  output logic                         cfg_err
);

  localparam int PIN_W = $clog2(NUM_PINS);
  // A zero guard still needs a one-bit counter so the state vector has a legal width.
  localparam int CNT_W = (GUARD_CYCLES > 0) ? $clog2(GUARD_CYCLES + 1) : 1;
  localparam int IDX_W = $clog2(NUM_PROJ * NUM_PINS);

  localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [SEL_W-1:0] SEL_PARK = {SEL_W{1'b1}};
  localparam logic [SEL_W-1:0] PROJ_LIM = SEL_W'(NUM_PROJ);

  logic [SEL_W-1:0]    sel_q [NUM_PINS];
  logic [SEL_W-1:0]    sel_d [NUM_PINS];
  logic [CNT_W-1:0]    cnt_q [NUM_PINS];
  logic [CNT_W-1:0]    cnt_d [NUM_PINS];
  logic [NUM_PINS-1:0] oeb_q, oeb_d;
  logic [NUM_PINS-1:0] out_q, out_d;
  logic                err_q, err_d;

  // Select table and guard counters: park_all beats writes, writes beat the countdown.
  always_comb begin
    for (int p = 0; p < NUM_PINS; p++) begin
      sel_d[p] = sel_q[p];
      cnt_d[p] = cnt_q[p];
      if (park_all) begin
        sel_d[p] = SEL_PARK;
        cnt_d[p] = '0;
      end else if (cfg_we && (cfg_pin == PIN_W'(p)) && (cfg_sel != sel_q[p])) begin
        sel_d[p] = cfg_sel;
        // Moving into the parked state is already safe, so it never pays a guard.
        cnt_d[p] = (cfg_sel >= PROJ_LIM) ? '0 : GUARD_LD;
      end else if (cnt_q[p] != '0) begin
        cnt_d[p] = cnt_q[p] - CNT_ONE;
      end
    end
  end

  // Output stage: tristate parked or guarded pins, otherwise pick the owner's bit for this pin.
  always_comb begin
    logic [IDX_W-1:0] idx;
    oeb_d = '1;
    out_d = '0;
    idx   = '0;
    for (int p = 0; p < NUM_PINS; p++) begin
      if ((sel_q[p] < PROJ_LIM) && (cnt_q[p] == '0)) begin
        idx      = IDX_W'(int'(sel_q[p]) * NUM_PINS + p);
        oeb_d[p] = io_oeb[idx];
        out_d[p] = io_out[idx];
      end
    end
  end

  // An out-of-range pin write is reported; a write swallowed by park_all is not.
  always_comb begin
    err_d = cfg_we && !park_all && (int'(cfg_pin) >= NUM_PINS);
  end

  // State and output registers; reset parks every pin without waiting for a clock.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int p = 0; p < NUM_PINS; p++) begin
        sel_q[p] <= SEL_PARK;
        cnt_q[p] <= '0;
      end
      oeb_q <= '1;
      out_q <= '0;
      err_q <= 1'b0;
    end else begin
      for (int p = 0; p < NUM_PINS; p++) begin
        sel_q[p] <= sel_d[p];
        cnt_q[p] <= cnt_d[p];
      end
      oeb_q <= oeb_d;
      out_q <= out_d;
      err_q <= err_d;
    end
  end

  // Busy flags come straight from the guard counters.
  always_comb begin
    for (int p = 0; p < NUM_PINS; p++) begin
      pin_busy[p] = (cnt_q[p] != '0);
    end
  end

  assign muxxed_io_oeb = oeb_q;
  assign muxxed_io_out = out_q;
  assign cfg_err       = err_q;

endmodule

// File: tb/tb_gpio_mux_ctrl.sv
// Purpose: directed and randomised checks of gpio_mux_ctrl with guard lengths 2, 0 and 3.
// Latency: outputs are sampled 1 time unit after each rising edge.
// Backpressure: not applicable; stimulus is free-running.
module tb_gpio_mux_ctrl;

  localparam int NP = 38;
  localparam int NJ = 13;
  localparam int GV [3] = '{2, 0, 3};

  logic               clk = 1'b0;
  logic               nrst;
  logic [NJ*NP-1:0]   io_oeb, io_out;
  logic               cfg_we;
  logic [5:0]         cfg_pin;
  logic [3:0]         cfg_sel;
  logic               park_all;
  logic [NP-1:0]      r_oeb  [3];
  logic [NP-1:0]      r_out  [3];
  logic [NP-1:0]      r_busy [3];
  logic               r_err  [3];

  int tests = 0;
  int fails = 0;

  logic [NP-1:0] e_oeb, e_out, e_busy;

  // Scoreboard state for the randomised phase.
  logic [3:0] ms [3][NP];
  int         mc [3][NP];

  always #5 clk = ~clk;

  gpio_mux_ctrl #(.NUM_PINS(NP), .NUM_PROJ(NJ), .SEL_W(4), .GUARD_CYCLES(2)) u_g2 (
    .clk(clk), .nrst(nrst), .io_oeb(io_oeb), .io_out(io_out),
    .cfg_we(cfg_we), .cfg_pin(cfg_pin), .cfg_sel(cfg_sel), .park_all(park_all),
    .muxxed_io_oeb(r_oeb[0]), .muxxed_io_out(r_out[0]), .pin_busy(r_busy[0]), .cfg_err(r_err[0]));

  gpio_mux_ctrl #(.NUM_PINS(NP), .NUM_PROJ(NJ), .SEL_W(4), .GUARD_CYCLES(0)) u_g0 (
    .clk(clk), .nrst(nrst), .io_oeb(io_oeb), .io_out(io_out),
    .cfg_we(cfg_we), .cfg_pin(cfg_pin), .cfg_sel(cfg_sel), .park_all(park_all),
    .muxxed_io_oeb(r_oeb[1]), .muxxed_io_out(r_out[1]), .pin_busy(r_busy[1]), .cfg_err(r_err[1]));

  gpio_mux_ctrl #(.NUM_PINS(NP), .NUM_PROJ(NJ), .SEL_W(4), .GUARD_CYCLES(3)) u_g3 (
    .clk(clk), .nrst(nrst), .io_oeb(io_oeb), .io_out(io_out),
    .cfg_we(cfg_we), .cfg_pin(cfg_pin), .cfg_sel(cfg_sel), .park_all(park_all),
    .muxxed_io_oeb(r_oeb[2]), .muxxed_io_out(r_out[2]), .pin_busy(r_busy[2]), .cfg_err(r_err[2]));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full-vector check of the guard-2 instance against the hand-tracked expectation.
  task automatic chk_vec(input string tag, input logic exp_err);
    chk({tag, "_oeb"},  64'(r_oeb[0]),  64'(e_oeb));
    chk({tag, "_out"},  64'(r_out[0]),  64'(e_out));
    chk({tag, "_busy"}, 64'(r_busy[0]), 64'(e_busy));
    chk({tag, "_err"},  64'(r_err[0]),  64'(exp_err));
  endtask

  task automatic set_src(input int j, input int p, input logic oeb, input logic out);
    io_oeb[j*NP+p] = oeb;
    io_out[j*NP+p] = out;
  endtask

  task automatic wr(input int pin, input int sel);
    cfg_we  = 1'b1;
    cfg_pin = 6'(pin);
    cfg_sel = 4'(sel);
    tick();
    cfg_we  = 1'b0;
  endtask

  // Predict all three instances from the pre-edge state, clock once, then compare.
  task automatic model_and_tick();
    logic [NP-1:0] eo [3];
    logic [NP-1:0] ex [3];
    logic [NP-1:0] eb [3];
    logic          ee;
    int            idx;
    ee = cfg_we && !park_all && (cfg_pin >= 6'd38);
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < NP; p++) begin
        if (ms[i][p] >= 4'd13 || mc[i][p] != 0) begin
          eo[i][p] = 1'b1;
          ex[i][p] = 1'b0;
        end else begin
          idx = int'(ms[i][p]) * NP + p;
          eo[i][p] = io_oeb[idx];
          ex[i][p] = io_out[idx];
        end
        if (park_all) begin
          ms[i][p] = 4'hF;
          mc[i][p] = 0;
        end else if (cfg_we && int'(cfg_pin) == p && cfg_sel != ms[i][p]) begin
          ms[i][p] = cfg_sel;
          mc[i][p] = (cfg_sel >= 4'd13) ? 0 : GV[i];
        end else if (mc[i][p] > 0) begin
          mc[i][p] = mc[i][p] - 1;
        end
        eb[i][p] = (mc[i][p] != 0);
      end
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rnd_oeb_g%0d", GV[i]),  64'(r_oeb[i]),  64'(eo[i]));
      chk($sformatf("rnd_out_g%0d", GV[i]),  64'(r_out[i]),  64'(ex[i]));
      chk($sformatf("rnd_busy_g%0d", GV[i]), 64'(r_busy[i]), 64'(eb[i]));
      chk($sformatf("rnd_err_g%0d", GV[i]),  64'(r_err[i]),  64'(ee));
    end
  endtask

  initial begin
    int writes;
    nrst = 1'b0; cfg_we = 1'b0; cfg_pin = '0; cfg_sel = '0; park_all = 1'b0;
    io_oeb = '0; io_out = '1;
    e_oeb = '1; e_out = '0; e_busy = '0;

    // Reset state, then stay parked even though every project enables every pin.
    repeat (2) tick();
    chk_vec("rst", 1'b0);
    nrst = 1'b1;
    repeat (3) tick();
    chk_vec("parked_after_rst", 1'b0);

    // Basic assignment: pin 5 <- project 3, two guard cycles.
    io_oeb = '1; io_out = '0;
    set_src(3, 5, 1'b0, 1'b1);
    wr(5, 3);
    e_busy[5] = 1'b1;
    chk_vec("basic_k", 1'b0);
    tick();
    chk_vec("basic_k1", 1'b0);
    tick();
    e_busy[5] = 1'b0;
    chk_vec("basic_k2", 1'b0);
    tick();
    e_oeb[5] = 1'b0; e_out[5] = 1'b1;
    chk_vec("basic_k3", 1'b0);

    // One-cycle data latency.
    set_src(3, 5, 1'b0, 1'b0);
    chk("lat_before", 64'(r_out[0][5]), 64'd1);
    tick();
    e_out[5] = 1'b0;
    chk_vec("lat_after", 1'b0);
    set_src(3, 5, 1'b0, 1'b1);
    tick();
    e_out[5] = 1'b1;
    chk_vec("lat_back", 1'b0);

    // Reassignment mid-guard on pin 6: 3 -> 7 gives three tristate edges, never project 3.
    set_src(3, 6, 1'b0, 1'b1);
    set_src(7, 6, 1'b0, 1'b0);
    wr(6, 3);
    e_busy[6] = 1'b1;
    chk_vec("reasg_k", 1'b0);
    wr(6, 7);
    chk_vec("reasg_k1", 1'b0);
    tick();
    chk_vec("reasg_k2", 1'b0);
    tick();
    e_busy[6] = 1'b0;
    chk_vec("reasg_k3", 1'b0);
    tick();
    e_oeb[6] = 1'b0; e_out[6] = 1'b0;
    chk_vec("reasg_k4", 1'b0);

    // Rewriting the current select must not start a guard.
    wr(5, 3);
    chk_vec("same_sel_k", 1'b0);
    tick();
    chk_vec("same_sel_k1", 1'b0);

    // Park writes: tristated one edge later, never busy.
    wr(5, 13);
    chk_vec("park13_k", 1'b0);
    tick();
    e_oeb[5] = 1'b1; e_out[5] = 1'b0;
    chk_vec("park13_k1", 1'b0);
    wr(6, 15);
    chk_vec("park15_k", 1'b0);
    tick();
    e_oeb[6] = 1'b1; e_out[6] = 1'b0;
    chk_vec("park15_k1", 1'b0);

    // Highest pin, highest project.
    set_src(12, 37, 1'b0, 1'b1);
    wr(37, 12);
    e_busy[37] = 1'b1;
    chk_vec("p37_k", 1'b0);
    tick();
    chk_vec("p37_k1", 1'b0);
    tick();
    e_busy[37] = 1'b0;
    chk_vec("p37_k2", 1'b0);
    tick();
    e_oeb[37] = 1'b0; e_out[37] = 1'b1;
    chk_vec("p37_k3", 1'b0);

    // Out-of-range pin: single cfg_err pulse, nothing else moves.
    wr(38, 1);
    chk_vec("pin38_k", 1'b1);
    tick();
    chk_vec("pin38_k1", 1'b0);

    // park_all with a concurrent write and an in-flight guard on pin 10.
    set_src(2, 10, 1'b0, 1'b1);
    set_src(1, 0, 1'b0, 1'b1);
    wr(10, 2);
    e_busy[10] = 1'b1;
    chk_vec("pa_pre", 1'b0);
    park_all = 1'b1; cfg_we = 1'b1; cfg_pin = 6'd0; cfg_sel = 4'd1;
    tick();
    park_all = 1'b0; cfg_we = 1'b0;
    e_busy = '0;
    chk_vec("pa_k", 1'b0);
    tick();
    e_oeb = '1; e_out = '0;
    chk_vec("pa_k1", 1'b0);
    repeat (3) tick();
    chk_vec("pa_hold", 1'b0);

    // Asynchronous reset in the middle of a guard.
    wr(37, 12);
    repeat (3) tick();
    e_oeb[37] = 1'b0; e_out[37] = 1'b1;
    chk_vec("pre_arst", 1'b0);
    set_src(4, 20, 1'b0, 1'b1);
    wr(20, 4);
    e_busy[20] = 1'b1;
    chk_vec("guard_arst", 1'b0);
    #3;
    nrst = 1'b0;
    #1;
    e_oeb = '1; e_out = '0; e_busy = '0;
    chk_vec("async_rst", 1'b0);
    @(posedge clk);
    #1;
    nrst = 1'b1;
    repeat (4) tick();
    chk_vec("post_rst", 1'b0);

    // Randomised regression across guard lengths 2, 0 and 3.
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < NP; p++) begin
        ms[i][p] = 4'hF;
        mc[i][p] = 0;
      end
    end
    writes = 0;
    for (int cyc = 0; cyc < 600 && writes < 60; cyc++) begin
      for (int k = 0; k < NJ*NP; k++) begin
        io_oeb[k] = 1'($urandom_range(0, 1));
        io_out[k] = 1'($urandom_range(0, 1));
      end
      cfg_we   = ($urandom_range(0, 2) == 0);
      cfg_pin  = ($urandom_range(0, 3) != 0) ? 6'($urandom_range(0, 5)) : 6'($urandom_range(0, 40));
      cfg_sel  = 4'($urandom_range(0, 15));
      park_all = ($urandom_range(0, 49) == 0);
      if (cfg_we) writes++;
      model_and_tick();
    end
    cfg_we = 1'b0;
    park_all = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      for (int k = 0; k < NJ*NP; k++) begin
        io_oeb[k] = 1'($urandom_range(0, 1));
        io_out[k] = 1'($urandom_range(0, 1));
      end
      model_and_tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
